// File: rtl/program_loader.sv
// program_loader: turns a UART byte stream into CPU program-download writes.
// Packet: SYNC_BYTE, len[7:0], len[15:8], then len little-endian halfwords.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN appends an XOR checksum
// byte covering every byte after SYNC_BYTE.
module program_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_HALFWORDS  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        prog_we,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] loaded_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMO_W = 32;
    localparam int unsigned IDX_W = 32;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE
    } state_t;
    localparam state_t BODY_END = CHECK;
`else
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DONE
    } state_t;
    localparam state_t BODY_END = DONE;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         lo_q, lo_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif
    logic               dl_q, dl_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        pin_q, pin_d;
    logic               we_q, we_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   lc_q, lc_d;

    logic [CNT_W-1:0]   len_full;
    logic               tmo_hit;

    assign download_program  = dl_q;
    assign instruction_index = idx_q;
    assign program_in        = pin_q;
    assign prog_we           = we_q;
    assign load_done         = done_q;
    assign load_error        = err_q;
    assign loaded_count      = lc_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        tmo_d    = tmo_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        dl_d     = dl_q;
        idx_d    = idx_q;
        pin_d    = pin_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        lc_d     = lc_q;
        tmo_hit  = 1'b0;
        len_full = {rx_data, len_q[7:0]};

        // Index advances the cycle after each write; cnt_q already holds the new count.
        if (we_q) begin
            idx_d = IDX_W'(cnt_q);
        end

        // Inter-byte watchdog, active only while a packet is open.
        if (state_q == IDLE || state_q == DONE) begin
            tmo_d = '0;
        end else if (rx_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
                tmo_hit = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = LEN_LO;
                    dl_d    = 1'b1;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d = len_full;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (32'(len_full) > MAX_HALFWORDS) begin
                        err_d   = 1'b1;
                        dl_d    = 1'b0;
                        state_d = IDLE;
                    end else if (len_full == '0) begin
                        state_d = BODY_END;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
            end
            DATA_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (rx_valid) begin
                    pin_d = {rx_data, lo_q};
                    we_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    state_d = (cnt_d == len_q) ? BODY_END : DATA_LO;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        dl_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                lc_d    = len_q;
                dl_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stalled packet: abandon it; writes already made stand.
        if (tmo_hit) begin
            err_d   = 1'b1;
            dl_d    = 1'b0;
            tmo_d   = '0;
            state_d = IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            tmo_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
            dl_q    <= 1'b0;
            idx_q   <= '0;
            pin_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lc_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            tmo_q   <= tmo_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
            dl_q    <= dl_d;
            idx_q   <= idx_d;
            pin_q   <= pin_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lc_q    <= lc_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: packet-position reference model,
// per-cycle output compare, and literal checks on the directed scenarios.
module tb_program_loader;

    localparam int unsigned TMO  = 16;
    localparam int          MAXH = 1024;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] program_in;
    logic        prog_we;
    logic        load_done;
    logic        load_error;
    logic [15:0] loaded_count;

    program_loader #(
        .SYNC_BYTE      (SYNC),
        .MAX_HALFWORDS  (MAXH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .download_program  (download_program),
        .instruction_index (instruction_index),
        .program_in        (program_in),
        .prog_we           (prog_we),
        .load_done         (load_done),
        .load_error        (load_error),
        .loaded_count      (loaded_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    logic [47:0] wq[$];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks byte position within the packet.
    logic        e_dl, e_we, e_done, e_err;
    logic [31:0] e_idx;
    logic [15:0] e_pin, e_cnt;
    logic        m_started = 1'b0;
    logic        m_in, m_donep, m_inc;
    int          m_pos, m_len, m_idle;
    logic [7:0]  m_lo, m_xor;

    always @(posedge clk) begin
        if (reset) begin
            e_dl = 0; e_we = 0; e_done = 0; e_err = 0;
            e_idx = 0; e_pin = 0; e_cnt = 0;
            m_in = 0; m_donep = 0; m_inc = 0;
            m_pos = 0; m_len = 0; m_idle = 0; m_lo = 0; m_xor = 0;
            m_started = 1'b1;
        end else if (m_started) begin
            e_we = 0;
            e_done = 0;
            if (m_inc) begin
                e_idx = e_idx + 32'd1;
                m_inc = 0;
            end
            if (m_donep) begin
                e_done = 1; e_cnt = 16'(m_len); e_dl = 0; m_donep = 0;
            end else if (!m_in) begin
                if (rx_valid && rx_data == SYNC) begin
                    m_in = 1; m_pos = 0; m_idle = 0; m_xor = 0;
                    e_dl = 1; e_err = 0; e_idx = 0;
                end
            end else if (rx_valid) begin
                m_idle = 0;
                m_pos++;
                if (m_pos == 1) begin
                    m_len = int'(rx_data);
                    m_xor ^= rx_data;
                end else if (m_pos == 2) begin
                    m_len = m_len + 256 * int'(rx_data);
                    m_xor ^= rx_data;
                    if (m_len > MAXH) begin
                        e_err = 1; e_dl = 0; m_in = 0;
                    end else if (m_len == 0) begin
`ifndef PROGRAM_LOADER_CHECKSUM_EN
                        m_in = 0; m_donep = 1;
`endif
                    end
                end else if (m_pos <= 2 + 2 * m_len) begin
                    m_xor ^= rx_data;
                    if (((m_pos - 3) % 2) == 0) begin
                        m_lo = rx_data;
                    end else begin
                        e_pin = {rx_data, m_lo};
                        e_we = 1;
                        m_inc = 1;
                    end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
                    if (m_pos == 2 + 2 * m_len) begin
                        m_in = 0; m_donep = 1;
                    end
`endif
                end else begin
                    if (rx_data == m_xor) begin
                        m_in = 0; m_donep = 1;
                    end else begin
                        e_err = 1; e_dl = 0; m_in = 0;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == int'(TMO)) begin
                    e_err = 1; e_dl = 0; m_in = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("download_program",  48'(download_program),  48'(e_dl));
            chk("instruction_index", 48'(instruction_index), 48'(e_idx));
            chk("program_in",        48'(program_in),        48'(e_pin));
            chk("prog_we",           48'(prog_we),           48'(e_we));
            chk("load_done",         48'(load_done),         48'(e_done));
            chk("load_error",        48'(load_error),        48'(e_err));
            chk("loaded_count",      48'(loaded_count),      48'(e_cnt));
            if (prog_we === 1'b1) wq.push_back({instruction_index, program_in});
            if (load_done === 1'b1) n_done++;
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base;
    int d0;

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);
        chk("rst_dl",  48'(download_program),  48'd0);
        chk("rst_idx", 48'(instruction_index), 48'd0);
        chk("rst_cnt", 48'(loaded_count),      48'd0);

        // Normal two-halfword load.
        base = wq.size(); d0 = n_done;
        send(8'hA5);
        chk("norm_dl_after_sync", 48'(download_program), 48'd1);
        send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'h0A);
`endif
        idle(4);
        chk("norm_writes", 48'(wq.size() - base), 48'd2);
        if (wq.size() >= base + 2) begin
            chk("norm_w0", wq[base],     {32'd0, 16'h1234});
            chk("norm_w1", wq[base + 1], {32'd1, 16'h5678});
        end
        chk("norm_done",  48'(n_done - d0),     48'd1);
        chk("norm_count", 48'(loaded_count),    48'd2);
        chk("norm_dl",    48'(download_program), 48'd0);

        // Garbage in IDLE is ignored.
        base = wq.size();
        send(8'h00); send(8'hFF); send(8'h12);
        idle(2);
        chk("garb_dl",     48'(download_program), 48'd0);
        chk("garb_writes", 48'(wq.size() - base), 48'd0);

        // Oversize length 1025, then a new sync clears the error.
        send(8'hA5); send(8'h01); send(8'h04);
        idle(2);
        chk("over_err",    48'(load_error),       48'd1);
        chk("over_dl",     48'(download_program), 48'd0);
        chk("over_writes", 48'(wq.size() - base), 48'd0);
        send(8'hA5);
        chk("over_clear",  48'(load_error),       48'd0);
        send(8'h00); send(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        idle(3);
        chk("len0_count", 48'(loaded_count), 48'd0);

        // Timeout after a partial halfword.
        base = wq.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h34);
        idle(int'(TMO) + 2);
        chk("tmo_err",    48'(load_error),       48'd1);
        chk("tmo_dl",     48'(download_program), 48'd0);
        chk("tmo_writes", 48'(wq.size() - base), 48'd0);

        // A byte on the expiry cycle keeps the packet alive.
        d0 = n_done;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h34);
        idle(int'(TMO) - 1);
        send(8'h12);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'h27);
`endif
        idle(3);
        chk("edge_err",  48'(load_error),   48'd0);
        chk("edge_done", 48'(n_done - d0),  48'd1);
        chk("edge_w",    wq[wq.size() - 1], {32'd0, 16'h1234});

        // Reset mid-load, then a fresh packet starts at index 0.
        send(8'hA5); send(8'h04); send(8'h00); send(8'h11);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rml_dl",  48'(download_program),  48'd0);
        chk("rml_idx", 48'(instruction_index), 48'd0);
        base = wq.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'hCD); send(8'hAB);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'h67);
`endif
        idle(3);
        chk("rml_writes", 48'(wq.size() - base), 48'd1);
        if (wq.size() > base) chk("rml_w0", wq[base], {32'd0, 16'hABCD});
        chk("rml_idx_after", 48'(instruction_index), 48'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        d0 = n_done;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h27);
        idle(3);
        chk("csum_ok_done", 48'(n_done - d0), 48'd1);
        chk("csum_ok_err",  48'(load_error),  48'd0);
        d0 = n_done;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h28);
        idle(3);
        chk("csum_bad_done",  48'(n_done - d0),      48'd0);
        chk("csum_bad_err",   48'(load_error),       48'd1);
        chk("csum_bad_dl",    48'(download_program), 48'd0);
        chk("csum_bad_count", 48'(loaded_count),     48'd1);
`endif

        // Sync value mid-packet is data.
        base = wq.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'hA5); send(8'hA5);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'h01);
`endif
        idle(3);
        if (wq.size() > base) chk("sync_data", wq[base], {32'd0, 16'hA5A5});
        else chk("sync_data_writes", 48'(wq.size() - base), 48'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder of the CPU top. It turns a serial byte stream from the UART receiver into the CPU's program-download interface: download_program, instruction_index and program_in.
- It parses a framed packet containing a sync byte, a halfword count and little-endian 16-bit instructions.
- It holds the core in download for the whole transfer and releases it to run when the transfer completes.
- It raises an error flag and returns to idle on a malformed or stalled packet.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-packet marker.
- MAX_HALFWORDS, 1024, icache capacity in 16-bit instructions; a larger count is rejected.
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles allowed between consecutive bytes inside a packet.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle. There is no backpressure.
- download_program  out  1  high while a packet is being loaded; stalls the CPU.
- instruction_index  out  32  icache write address, in halfwords.
- program_in  out  16  instruction to write.
- prog_we  out  1  one-cycle pulse; instruction_index and program_in are valid this cycle.
- load_done  out  1  one-cycle pulse when a packet completes successfully.
- load_error  out  1  sticky error flag; cleared by reset or by acceptance of the next SYNC_BYTE.
- loaded_count  out  16  number of halfwords written by the last successful load.

Behaviour:
- Reset values: download_program=0, instruction_index=0, program_in=0, prog_we=0, load_done=0, load_error=0, loaded_count=0, state=IDLE, timeout counter=0.
- All outputs are registered. Each effect appears one cycle after the rx_valid cycle that causes it.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK (only with the optional feature), DONE.
- IDLE:
  - download_program=0.
  - rx_valid with rx_data==SYNC_BYTE → LEN_LO. Set download_program=1, clear load_error, set instruction_index=0.
  - Any other byte is ignored.
- LEN_LO: latch byte as len[7:0] → LEN_HI.
- LEN_HI: latch byte as len[15:8].
  - len==0 → DONE (or CHECK).
  - len>MAX_HALFWORDS → set load_error, go to IDLE.
  - Otherwise → DATA_LO.
- DATA_LO: latch byte as the low byte → DATA_HI.
- DATA_HI, on rx_valid:
  - program_in = {byte, low}; pulse prog_we with the current instruction_index.
  - Next cycle, instruction_index increments by 1.
  - When the halfword count reaches len → DONE (or CHECK). Otherwise → DATA_LO.
- DONE:
  - load_done pulses for one cycle; loaded_count=len; download_program=0.
  - Next state IDLE; instruction_index holds its last value.
- Timeout:
  - In LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK, a counter increments every cycle without rx_valid and resets to 0 on rx_valid.
  - Reaching TIMEOUT_CYCLES → set load_error, download_program=0, go to IDLE.
  - Halfwords already written stay written; loaded_count is unchanged.
- Sync inside a packet: a SYNC_BYTE value received mid-packet is treated as data. There is no resync until IDLE.
- Reset mid-load: on the next clk edge all outputs return to their reset values and the CPU is released from download.
- Simultaneous events: rx_valid in the same cycle the timeout counter would expire counts as a received byte, and the timeout does not fire.
- Arithmetic:
  - instruction_index is zero-extended from the 16-bit count.
  - The halfword counter is 16 bits wide and never wraps, because len≤MAX_HALFWORDS.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last data byte (or after LEN_HI when len==0) the FSM enters CHECK and waits for one more byte.
  - That byte must equal the XOR of every byte after SYNC_BYTE: both length bytes and all data bytes.
  - Match → DONE.
  - Mismatch → set load_error, go to IDLE, no load_done, loaded_count unchanged. download_program still drops to 0.
- Without the macro: the CHECK state and the XOR register are absent, and the packet ends directly after the last data byte.

Test Plan:
- Normal load: bytes A5,02,00,34,12,78,56 →
  - prog_we at index 0 with program_in 16'h1234.
  - prog_we at index 1 with program_in 16'h5678.
  - load_done pulses once; loaded_count=2.
  - download_program is high from the cycle after A5 until the DONE cycle, then 0.
- Idle garbage: bytes 00,FF,12 in IDLE → no output change, download_program stays 0.
- Oversize length: A5,01,04 (len 1025) → load_error=1, state returns to IDLE, no prog_we; a following A5 clears load_error.
- Timeout: A5,01,00,34, then no bytes for TIMEOUT_CYCLES →
  - load_error=1, download_program=0, no prog_we.
  - A rx_valid arriving exactly on the expiry cycle prevents the error.
- Reset mid-load: reset asserted after A5,04,00,11 → next cycle download_program=0, instruction_index=0; a fresh packet then loads from index 0.
- Checksum (macro defined):
  - A5,01,00,34,12,27 → load_done (27 = 01^00^34^12).
  - The same packet with a final byte of 28 → load_error=1, no load_done.
